// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: Fibonacci LFSR tap table, feedback function and checker state encoding.
// Imported by both the PRBS generator and prbs_checker so their tap tables stay identical.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int max_width = 128;
  localparam int idx_w     = $clog2(max_width);

  // Lower taps only (0-based); the top bit width-1 always participates.
  function automatic logic is_tap(input int width, input int index);
    logic tap;
    case (width)
      3:       tap = (index == 1);
      4:       tap = (index == 2);
      5:       tap = (index == 2);
      6:       tap = (index == 4);
      7:       tap = (index == 5);
      8:       tap = (index == 5) || (index == 4) || (index == 3);
      15:      tap = (index == 13);
      16:      tap = (index == 14) || (index == 12) || (index == 3);
      31:      tap = (index == 27);
      32:      tap = (index == 21) || (index == 1) || (index == 0);
      63:      tap = (index == 61);
      64:      tap = (index == 62) || (index == 60) || (index == 59);
      127:     tap = (index == 125);
      128:     tap = (index == 125) || (index == 100) || (index == 98);
      default: tap = 1'b0;
    endcase
    return tap;
  endfunction

  function automatic logic feedback(input logic [max_width-1:0] hist, input int width);
    logic fb;
    fb = hist[idx_w'(width - 1)];
    for (int i = 0; i < max_width - 1; i++) begin
      if (i < width - 1 && is_tap(width, i)) fb = fb ^ hist[idx_w'(i)];
    end
    return fb;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment coincident with clear yields 1.
module sat_counter #(
  parameter int width = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [width-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? width'(1) : '0;
    end else if (inc && count != '1) begin
      count <= count + width'(1);
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS receive checker: self-seeds from the stream, verifies lock, then free-runs and counts bit errors.
// Define PRBS_CHECK_BIT_COUNT_EN to add bit_count, a saturating count of bits consumed while locked.
//   state  | meaning
//   SEED   | filling hist with width received bits
//   VERIFY | predicting received bits; lock_count hits in a row declare lock
//   LOCKED | free-running on predicted bits, counting mismatches per window
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int width         = 7,
  parameter int lock_count    = 16,
  parameter int window_log2   = 8,
  parameter int unlock_errors = 4,
  parameter int cnt_width     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error,
  output logic [cnt_width-1:0] err_count
`ifdef PRBS_CHECK_BIT_COUNT_EN
  ,
  output logic [cnt_width-1:0] bit_count
`endif
);

  localparam int seed_w  = $clog2(width);
  localparam int match_w = $clog2(lock_count + 1);
  localparam int werr_w  = $clog2(unlock_errors + 1);

  state_t                 state;
  logic [width-1:0]       hist;
  logic [seed_w-1:0]      seed_cnt;
  logic [match_w-1:0]     match_cnt;
  logic [window_log2-1:0] win_cnt;
  logic [werr_w-1:0]      win_err;
  logic [werr_w-1:0]      win_err_base;
  logic                   expected;
  logic                   mismatch;
  logic                   err_event;

  assign expected  = feedback(max_width'(hist), width);
  assign mismatch  = in ^ expected;
  assign err_event = enable && (state == LOCKED) && mismatch;
  // The bit at win_cnt == 0 opens a new window, so its error counts from zero.
  assign win_err_base = (win_cnt == '0) ? '0 : win_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= SEED;
      hist      <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      error     <= 1'b0;
    end else begin
      error <= 1'b0;
      if (enable) begin
        case (state)
          SEED: begin
            hist <= {hist[width-2:0], in};
            if (seed_cnt == seed_w'(width - 1)) begin
              seed_cnt <= '0;
              if ({hist[width-2:0], in} != '0) begin
                state     <= VERIFY;
                match_cnt <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + seed_w'(1);
            end
          end
          VERIFY: begin
            hist <= {hist[width-2:0], in};
            if (mismatch) begin
              state    <= SEED;
              seed_cnt <= '0;
            end else if (match_cnt == match_w'(lock_count - 1)) begin
              state   <= LOCKED;
              locked  <= 1'b1;
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              match_cnt <= match_cnt + match_w'(1);
            end
          end
          LOCKED: begin
            // Shift the prediction so a corrupted bit never reaches the taps.
            hist    <= {hist[width-2:0], expected};
            win_cnt <= win_cnt + window_log2'(1);
            error   <= mismatch;
            win_err <= win_err_base + werr_w'(mismatch);
            if (mismatch && (win_err_base + werr_w'(1) == werr_w'(unlock_errors))) begin
              state    <= SEED;
              seed_cnt <= '0;
              locked   <= 1'b0;
            end
          end
          default: state <= SEED;
        endcase
      end
    end
  end

  sat_counter #(.width(cnt_width)) u_err_count (
    .clock (clock),
    .reset (reset),
    .inc   (err_event),
    .clr   (clear),
    .count (err_count)
  );

`ifdef PRBS_CHECK_BIT_COUNT_EN
  sat_counter #(.width(cnt_width)) u_bit_count (
    .clock (clock),
    .reset (reset),
    .inc   (enable && (state == LOCKED) && !clear),
    .clr   (clear),
    .count (bit_count)
  );
`endif

endmodule
